// File: rtl/gate_sweep_pkg.sv
// Shared types and default parameters for the gate_sweep_ctrl self-test sequencer.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } sweep_state_t;

  localparam int          DEF_N           = 4;
  localparam int          DEF_SETTLE      = 2;
  localparam logic [15:0] DEF_GOLDEN_AND4 = 16'h8000;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that times how long each vector is held
// on the gate inputs. expired is high while the count is zero.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int            W      = $clog2(SETTLE) + 1;
  localparam logic [W-1:0]  RELOAD = W'(SETTLE - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on WAIT entry, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (dec && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives every input pattern 0..2^N-1 onto a combinational
// gate, holds each for SETTLE cycles, samples the gate output into table_out
// and pulses done at the end of the sweep.
// Optional compare against GOLDEN is built only when GATE_SWEEP_CHECK_EN is
// defined; otherwise pass and err_cnt are tied to zero.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int               N      = DEF_N,
  parameter int               SETTLE = DEF_SETTLE,
  parameter logic [2**N-1:0]  GOLDEN = DEF_GOLDEN_AND4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic [N-1:0]    a_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] table_out,
  output logic            pass,
  output logic [N:0]      err_cnt
);

  localparam int           V        = 2**N;
  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

  sweep_state_t   state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [N-1:0]   a_out_q, a_out_d;
  logic [V-1:0]   table_q, table_d;
  logic           busy_q;
  logic           done_q;
  logic           load_s;
  logic           dec_s;
  logic           expired_s;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_s),
    .dec     (dec_s),
    .expired (expired_s)
  );

  // Sweep sequencing: next state, vector index, gate drive and captured table.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_out_d = a_out_q;
    table_d = table_q;
    load_s  = 1'b0;
    dec_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = {N{1'b0}};
          a_out_d = {N{1'b0}};
          table_d = {V{1'b0}};
          load_s  = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (expired_s) begin
          state_d = S_SAMPLE;
        end else begin
          dec_s   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_SAMPLE: begin
        table_d[idx_q] = y_in;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          a_out_d = idx_q + 1'b1;
          load_s  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        idx_d   = {N{1'b0}};
        a_out_d = {N{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sweep state and output registers; busy/done follow the next state so
  // they line up with the cycle the FSM is actually in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= {N{1'b0}};
      a_out_q <= {N{1'b0}};
      table_q <= {V{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_out_q <= a_out_d;
      table_q <= table_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign a_out     = a_out_q;
  assign table_out = table_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef GATE_SWEEP_CHECK_EN
  logic [N:0] err_q, err_d;
  logic       pass_q, pass_d;

  // Golden compare: count mismatching vectors, latch the verdict as the
  // sweep enters DONE so pass is already valid in the done cycle.
  always_comb begin
    err_d  = err_q;
    pass_d = pass_q;
    if ((state_q == S_IDLE) && start) begin
      err_d  = {(N+1){1'b0}};
      pass_d = 1'b0;
    end else if (state_q == S_SAMPLE) begin
      if (y_in != GOLDEN[idx_q]) begin
        err_d = err_q + {{N{1'b0}}, 1'b1};
      end else begin
        err_d = err_q;
      end
      if (idx_q == IDX_LAST) begin
        pass_d = (err_d == {(N+1){1'b0}});
      end else begin
        pass_d = pass_q;
      end
    end else begin
      err_d  = err_q;
      pass_d = pass_q;
    end
  end

  // Compare result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q  <= {(N+1){1'b0}};
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      pass_q <= pass_d;
    end
  end

  assign err_cnt = err_q;
  assign pass    = pass_q;
`else
  assign err_cnt = {(N+1){1'b0}};
  assign pass    = 1'b0;
`endif

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-test sequencer for the 4-input combinational `gates` block. On a start request it drives every input pattern 0..2^N-1 onto the gate inputs, waits a settle interval, and samples the gate output into a truth-table register. Completion is reported with a one-cycle done pulse. It sits between the lab-board control logic and the `gates` instance, so the gate is exercised in hardware rather than only by a stimulus bench.

## Interface
- N, 4: gate input width; the sweep covers 2^N vectors.
- SETTLE, 2: cycles each vector is held before sampling; legal range ≥1.
- GOLDEN, 16'h8000: expected truth table (AND4), width 2^N; used only with the check feature.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- a_out  out  N  registered drive to the gate inputs.
- y_in  in  1  gate output.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at sweep end.
- table_out  out  2^N  captured truth table; bit i = y_in sampled with a_out = i.
- pass  out  1  table_out == GOLDEN; valid from done onward.
- err_cnt  out  N+1  number of vectors where y_in ≠ GOLDEN[i].

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- Reset values: state IDLE, idx 0, a_out 0, cnt 0, table_out 0, busy 0, done 0, pass 0, err_cnt 0.
- IDLE, start=1:
  - idx←0, a_out←0, cnt←SETTLE-1.
  - Clear table_out, err_cnt and pass.
  - Go to WAIT.
- IDLE, start=0: hold all outputs; table_out keeps the last result.
- WAIT: a_out = idx. Decrement cnt; when cnt==0 go to SAMPLE.
- SAMPLE:
  - table_out[idx]←y_in.
  - If idx == 2^N-1, go to DONE.
  - Otherwise idx←idx+1, a_out←idx+1, cnt←SETTLE-1, go to WAIT.
- DONE:
  - done=1 for exactly this cycle.
  - a_out←0, idx←0, go to IDLE.
- start is ignored while busy; a held-high start begins a new sweep on the first cycle back in IDLE.
- idx is N bits wide; the terminal test uses idx == 2^N-1, so idx never wraps.
- An async reset mid-sweep aborts immediately to reset values, including clearing table_out. No done pulse is issued.

## Timing
- start accepted at edge k, so WAIT occupies cycles k+1..k+SETTLE.
- Each vector costs SETTLE+1 cycles.
- Last SAMPLE is at cycle k+2^N·(SETTLE+1); done is high in cycle k+2^N·(SETTLE+1)+1.
- Defaults: done in cycle k+49. With SETTLE=1: cycle k+33.
- a_out changes only on WAIT entry, and is stable for at least SETTLE cycles before it is sampled.
- table_out, pass and err_cnt are stable from done until the next accepted start.

## Configuration
- GATE_SWEEP_CHECK_EN defined:
  - In SAMPLE, err_cnt increments when y_in ≠ GOLDEN[idx].
  - In DONE, pass←(err_cnt_next == 0).
- Not defined:
  - pass and err_cnt are tied 0 and no compare logic is built.
  - The sweep and table_out behaviour are unchanged.

## Structure
- Package gate_sweep_pkg holds:
  - the state enum type `sweep_state_t`;
  - defaults DEF_N=4, DEF_SETTLE=2, DEF_GOLDEN_AND4=16'h8000.
- One sub-module, settle_timer:
  - loadable down-counter of width $clog2(SETTLE)+1;
  - outputs `expired` when the count is 0;
  - reloaded by the FSM on each WAIT entry.

## Test plan
- AND4 model on y_in, defaults, start pulse -> done in cycle k+49, table_out=16'h8000, pass=1, err_cnt=0.
- OR4 model, GOLDEN=16'h8000, check enabled -> table_out=16'hFFFE, err_cnt=14, pass=0.
- Gate model with a 1-cycle output delay, SETTLE=1 -> table_out still correct, because sampling happens after settle; a_out is observed stepping 0..15 every 2 cycles, then returning to 0.
- start held high for the entire run -> one done per sweep, back-to-back sweeps, busy low for exactly one cycle between them.
- reset_n asserted low at vector 7 -> all outputs immediately at reset values, no done pulse; a subsequent start gives a full correct sweep.
- Check macro undefined, OR4 model -> table_out=16'hFFFE, pass=0, err_cnt=0 throughout.
